// File: rtl/cic_decimator.sv
// ---------------------------------------------------------------------------
// cic_decimator
//
// Multi-channel CIC (Hogenauer) decimation filter for 1-bit sigma-delta / PDM
// bitstreams. Each channel runs ORDER cascaded integrators at the input rate.
// Every RATIO = 2**LOG2R accepted samples, the last integrator value is
// decimated into an ORDER-stage comb pipeline. The comb result is then
// scaled, saturated and presented as a signed OUT_W-bit PCM sample. All
// channels share one decimation counter, so a single OUT_VALID pulse frames
// every channel at once. The first ORDER-1 decimated results after reset or
// clear are filter transients and are suppressed.
//
// Parameters
//   CH     number of bitstream channels
//   ORDER  number of integrator / comb stages (1..6)
//   LOG2R  log2 of the decimation ratio
//   OUT_W  output sample width, OUT_W <= ORDER*LOG2R+1
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active low
//   CLR        synchronous clear, active high, same effect as RST
//   IN_EN      input-sample strobe; IN is consumed only when high
//   IN[CH]     one bitstream bit per channel (1 -> +1, 0 -> -1)
//   OUT        signed PCM samples, channel c at [c*OUT_W +: OUT_W]
//   OUT_VALID  one-cycle pulse marking a new frame on OUT
// ---------------------------------------------------------------------------
module cic_decimator #(
    parameter int CH    = 1,
    parameter int ORDER = 3,
    parameter int LOG2R = 6,
    parameter int OUT_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    input  logic                IN_EN,
    input  logic [CH-1:0]       IN,
    output logic [CH*OUT_W-1:0] OUT,
    output logic                OUT_VALID
);

    // Bit growth of the filter is ORDER*LOG2R; the comb result spans
    // [-2**G, +2**G], which needs G+2 bits including the sign.
    localparam int G     = ORDER * LOG2R;
    localparam int ACC_W = G + 2;
    localparam int SHIFT = G + 1 - OUT_W;
    localparam int WU_W  = (ORDER > 1) ? $clog2(ORDER) : 1;

    localparam logic [WU_W-1:0]         WU_DONE = WU_W'(ORDER - 1);
    localparam logic [LOG2R-1:0]        CNT_ONE = LOG2R'(1);
    localparam logic signed [ACC_W-1:0] ONE_P   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ONE_N   = '1;
    localparam logic signed [ACC_W-1:0] SAT_HI  =
        ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    // Arithmetic shift down to OUT_W bits. Only v = +2**G can exceed the
    // positive range after the shift, so only the upper bound is clamped.
    function automatic logic signed [OUT_W-1:0] scale_sat(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > SAT_HI) begin
            return OUT_MAX;
        end
        return OUT_W'(s);
    endfunction

    // Decimation timebase shared by all channels
    logic [LOG2R-1:0]        cnt_q, cnt_d;
    // Integrators, input rate
    logic signed [ACC_W-1:0] integ_q [CH][ORDER];
    logic signed [ACC_W-1:0] integ_d [CH][ORDER];
    // Decimated capture (pipeline stage 0)
    logic signed [ACC_W-1:0] cap_p0_q [CH];
    logic signed [ACC_W-1:0] cap_p0_d [CH];
    logic                    vld_p0_q, vld_p0_d;
    // Comb stages: output register and differential delay per stage
    logic signed [ACC_W-1:0] comb_q [CH][ORDER];
    logic signed [ACC_W-1:0] comb_d [CH][ORDER];
    logic signed [ACC_W-1:0] dly_q  [CH][ORDER];
    logic signed [ACC_W-1:0] dly_d  [CH][ORDER];
    logic [ORDER-1:0]        cvld_q, cvld_d;
    // Warm-up suppression and output register
    logic [WU_W-1:0]         wu_q, wu_d;
    logic [CH*OUT_W-1:0]     out_q, out_d;
    logic                    ovld_q, ovld_d;

    always_comb begin : next_state
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] feed;
        logic                    tok;

        acc      = '0;
        feed     = '0;
        tok      = 1'b0;
        cnt_d    = cnt_q;
        integ_d  = integ_q;
        cap_p0_d = cap_p0_q;
        vld_p0_d = 1'b0;
        comb_d   = comb_q;
        dly_d    = dly_q;
        cvld_d   = '0;
        wu_d     = wu_q;
        out_d    = out_q;
        ovld_d   = 1'b0;

        // ---- input rate: integrators and decimation capture ----
        if (IN_EN) begin
            cnt_d = cnt_q + CNT_ONE;
            for (int c = 0; c < CH; c++) begin
                // Each stage sees the freshly updated value of the stage
                // before it, so the last integrator includes this sample.
                acc = IN[c] ? ONE_P : ONE_N;
                for (int k = 0; k < ORDER; k++) begin
                    integ_d[c][k] = integ_q[c][k] + acc;
                    acc           = integ_d[c][k];
                end
                if (&cnt_q) begin
                    cap_p0_d[c] = acc;
                end
            end
            vld_p0_d = &cnt_q;
        end

        // ---- decimated rate: comb stages advance on the valid token ----
        for (int c = 0; c < CH; c++) begin
            feed = cap_p0_q[c];
            tok  = vld_p0_q;
            for (int k = 0; k < ORDER; k++) begin
                cvld_d[k] = tok;
                if (tok) begin
                    comb_d[c][k] = feed - dly_q[c][k];
                    dly_d[c][k]  = feed;
                end
                feed = comb_q[c][k];
                tok  = cvld_q[k];
            end
        end

        // ---- output: warm-up gate, scaling and saturation ----
        if (cvld_q[ORDER-1]) begin
            if (wu_q != WU_DONE) begin
                wu_d = wu_q + WU_W'(1);
            end else begin
                for (int c = 0; c < CH; c++) begin
                    out_d[c*OUT_W +: OUT_W] = scale_sat(comb_q[c][ORDER-1]);
                end
                ovld_d = 1'b1;
            end
        end

        // Clear overrides everything, including a sample in the same cycle
        if (CLR) begin
            cnt_d    = '0;
            vld_p0_d = 1'b0;
            cvld_d   = '0;
            wu_d     = '0;
            out_d    = '0;
            ovld_d   = 1'b0;
            for (int c = 0; c < CH; c++) begin
                cap_p0_d[c] = '0;
                for (int k = 0; k < ORDER; k++) begin
                    integ_d[c][k] = '0;
                    comb_d[c][k]  = '0;
                    dly_d[c][k]   = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q    <= '0;
            vld_p0_q <= 1'b0;
            cvld_q   <= '0;
            wu_q     <= '0;
            out_q    <= '0;
            ovld_q   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                cap_p0_q[c] <= '0;
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[c][k] <= '0;
                    comb_q[c][k]  <= '0;
                    dly_q[c][k]   <= '0;
                end
            end
        end else begin
            cnt_q    <= cnt_d;
            vld_p0_q <= vld_p0_d;
            cvld_q   <= cvld_d;
            wu_q     <= wu_d;
            out_q    <= out_d;
            ovld_q   <= ovld_d;
            for (int c = 0; c < CH; c++) begin
                cap_p0_q[c] <= cap_p0_d[c];
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[c][k] <= integ_d[c][k];
                    comb_q[c][k]  <= comb_d[c][k];
                    dly_q[c][k]   <= dly_d[c][k];
                end
            end
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = ovld_q;

endmodule

// File: tb/tb_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_cic_decimator
//
// Three instances share one clock:
//   dut_a  CH=2, ORDER=3, LOG2R=6, OUT_W=8   (reset, full scale, gaps, clear)
//   dut_b  CH=1, ORDER=3, LOG2R=6, OUT_W=8   (periodic patterns)
//   dut_c  CH=1, ORDER=4, LOG2R=5, OUT_W=12  (long run with integrator wrap)
// Inputs change and outputs are sampled on the falling edge. Cycle n counts
// rising edges after reset release; sample n is absorbed at edge n.
// Expected values (ORDER=3, LOG2R=6, OUT_W=8 -> shift 11):
//   all ones   v = +2**18 -> 128 -> saturated 8'h7F
//   all zeros  v = -2**18 -> -128 = 8'h80
//   1,0        v = 0      -> 8'h00
//   1,1,1,0    v = +2**17 -> 64  = 8'h40
//   1,0,0,0    v = -2**17 -> -64 = 8'hC0
//   ORDER=4, LOG2R=5, OUT_W=12, 1,1,1,0: v = 2**19 >>> 9 = 1024
// ---------------------------------------------------------------------------
module tb_cic_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, clr_a, en_a;
    logic [1:0]  in_a;
    logic [15:0] out_a;
    logic        vld_a;

    logic        rst_b, clr_b, en_b;
    logic [0:0]  in_b;
    logic [7:0]  out_b;
    logic        vld_b;

    logic        rst_c, clr_c, en_c;
    logic [0:0]  in_c;
    logic [11:0] out_c;
    logic        vld_c;

    int checks   = 0;
    int failures = 0;

    cic_decimator #(.CH(2), .ORDER(3), .LOG2R(6), .OUT_W(8)) dut_a (
        .CLK(clk), .RST(rst_a), .CLR(clr_a), .IN_EN(en_a), .IN(in_a),
        .OUT(out_a), .OUT_VALID(vld_a)
    );

    cic_decimator #(.CH(1), .ORDER(3), .LOG2R(6), .OUT_W(8)) dut_b (
        .CLK(clk), .RST(rst_b), .CLR(clr_b), .IN_EN(en_b), .IN(in_b),
        .OUT(out_b), .OUT_VALID(vld_b)
    );

    cic_decimator #(.CH(1), .ORDER(4), .LOG2R(5), .OUT_W(12)) dut_c (
        .CLK(clk), .RST(rst_c), .CLR(clr_c), .IN_EN(en_c), .IN(in_c),
        .OUT(out_c), .OUT_VALID(vld_c)
    );

    // ch1 = 8'h80 (all zeros), ch0 = 8'h7F (all ones, saturated)
    localparam logic [15:0] FS_OUT = 16'h807F;

    task automatic test_reset();
        rst_a = 1'b0; en_a = 1'b1; in_a = 2'b01;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checks++;
            if (out_a !== 16'h0000) begin
                failures++;
                $display("FAIL reset_out cycle %0d: got %h, want 0000", n, out_a);
            end
            checks++;
            if (vld_a !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cycle %0d: got %b, want 0", n, vld_a);
            end
            in_a = ~in_a;
        end
    endtask

    task automatic test_full_scale();
        logic        exp_v;
        logic [15:0] exp_o;
        rst_a = 1'b1; en_a = 1'b1; in_a = 2'b01;
        for (int n = 1; n <= 196 + 64 * 3; n++) begin
            @(negedge clk);
            exp_v = (n >= 196) && (((n - 196) % 64) == 0);
            exp_o = (n >= 196) ? FS_OUT : 16'h0000;
            checks++;
            if (vld_a !== exp_v) begin
                failures++;
                $display("FAIL fs_valid cycle %0d: got %b, want %b", n, vld_a, exp_v);
            end
            checks++;
            if (out_a !== exp_o) begin
                failures++;
                $display("FAIL fs_out cycle %0d: got %h, want %h", n, out_a, exp_o);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_gapped();
        logic        exp_v;
        logic [15:0] exp_o;
        @(negedge clk); rst_a = 1'b0; en_a = 1'b0;
        @(negedge clk); rst_a = 1'b1; en_a = 1'b1; in_a = 2'b01;
        // enabled on cycles 1,5,9,...; sample 192 lands on cycle 765
        for (int n = 1; n <= 769 + 512; n++) begin
            @(negedge clk);
            exp_v = (n >= 769) && (((n - 769) % 256) == 0);
            exp_o = (n >= 769) ? FS_OUT : 16'h0000;
            checks++;
            if (vld_a !== exp_v) begin
                failures++;
                $display("FAIL gap_valid cycle %0d: got %b, want %b", n, vld_a, exp_v);
            end
            checks++;
            if (out_a !== exp_o) begin
                failures++;
                $display("FAIL gap_out cycle %0d: got %h, want %h", n, out_a, exp_o);
            end
            en_a = ((n % 4) == 0);
            in_a = en_a ? 2'b01 : 2'b10;
        end
        en_a = 1'b0;
    endtask

    task automatic test_clear();
        logic        exp_v;
        logic [15:0] exp_o;
        @(negedge clk); rst_a = 1'b0; en_a = 1'b0;
        @(negedge clk); rst_a = 1'b1; en_a = 1'b1; in_a = 2'b01; clr_a = 1'b0;
        // CLR on cycle 100 (with IN_EN high): samples restart at cycle 101,
        // so the first frame lands on cycle 296. CLR again on cycle 301.
        for (int n = 1; n <= 310; n++) begin
            @(negedge clk);
            exp_v = (n == 296);
            exp_o = (n >= 296 && n <= 300) ? FS_OUT : 16'h0000;
            checks++;
            if (vld_a !== exp_v) begin
                failures++;
                $display("FAIL clr_valid cycle %0d: got %b, want %b", n, vld_a, exp_v);
            end
            checks++;
            if (out_a !== exp_o) begin
                failures++;
                $display("FAIL clr_out cycle %0d: got %h, want %h", n, out_a, exp_o);
            end
            clr_a = ((n + 1) == 100) || ((n + 1) == 301);
        end
        clr_a = 1'b0; en_a = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk); rst_a = 1'b0; en_a = 1'b0;
        @(negedge clk); rst_a = 1'b1; en_a = 1'b1; in_a = 2'b01;
        for (int n = 1; n <= 258; n++) begin
            @(negedge clk);
        end
        checks++;
        if (out_a !== FS_OUT) begin
            failures++;
            $display("FAIL arst_pre_out: got %h, want %h", out_a, FS_OUT);
        end
        // frame from sample 256 is in the comb pipeline; reset between edges
        @(posedge clk);
        #2 rst_a = 1'b0;
        #1;
        checks++;
        if (out_a !== 16'h0000) begin
            failures++;
            $display("FAIL arst_out_immediate: got %h, want 0000", out_a);
        end
        checks++;
        if (vld_a !== 1'b0) begin
            failures++;
            $display("FAIL arst_valid_immediate: got %b, want 0", vld_a);
        end
        @(negedge clk); rst_a = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            checks++;
            if (vld_a !== (n == 196)) begin
                failures++;
                $display("FAIL arst_valid cycle %0d: got %b, want %b", n, vld_a, (n == 196));
            end
            checks++;
            if (out_a !== ((n >= 196) ? FS_OUT : 16'h0000)) begin
                failures++;
                $display("FAIL arst_out cycle %0d: got %h", n, out_a);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_patterns();
        logic [3:0] pats [3];
        logic [7:0] exps [3];
        logic       exp_v;
        pats[0] = 4'b0101; exps[0] = 8'h00;
        pats[1] = 4'b0111; exps[1] = 8'h40;
        pats[2] = 4'b0001; exps[2] = 8'hC0;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); rst_b = 1'b0; en_b = 1'b0;
            @(negedge clk); rst_b = 1'b1; en_b = 1'b1; in_b[0] = pats[p][0];
            for (int n = 1; n <= 196 + 128; n++) begin
                @(negedge clk);
                exp_v = (n >= 196) && (((n - 196) % 64) == 0);
                checks++;
                if (vld_b !== exp_v) begin
                    failures++;
                    $display("FAIL pat%0d_valid cycle %0d: got %b, want %b", p, n, vld_b, exp_v);
                end
                if (n >= 196) begin
                    checks++;
                    if (out_b !== exps[p]) begin
                        failures++;
                        $display("FAIL pat%0d_out cycle %0d: got %h, want %h", p, n, out_b, exps[p]);
                    end
                end
                in_b[0] = pats[p][n % 4];
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_long_wrap();
        localparam int NS = 20000;
        logic [3:0]  pat;
        longint      msk, ig [4], dl [4], c, t, v, o;
        int          phase, dec, pulses;
        int          expq [$];
        logic [11:0] e;
        logic        b;
        pat = 4'b0111;
        msk = (longint'(1) << 22) - 1;
        for (int k = 0; k < 4; k++) begin
            ig[k] = 0;
            dl[k] = 0;
        end
        phase = 0; dec = 0; pulses = 0;
        @(negedge clk); rst_c = 1'b0; en_c = 1'b0;
        @(negedge clk); rst_c = 1'b1;
        for (int n = 1; n <= NS + 8; n++) begin
            if (n <= NS) begin
                b = pat[(n - 1) % 4];
                en_c = 1'b1;
                in_c[0] = b;
                // modular reference: 22-bit integrators and combs
                ig[0] = (ig[0] + (b ? longint'(1) : msk)) & msk;
                for (int k = 1; k < 4; k++) ig[k] = (ig[k] + ig[k-1]) & msk;
                phase++;
                if (phase == 32) begin
                    phase = 0;
                    c = ig[3];
                    for (int k = 0; k < 4; k++) begin
                        t = (c - dl[k]) & msk;
                        dl[k] = c;
                        c = t;
                    end
                    v = (c >= (longint'(1) << 21)) ? c - (longint'(1) << 22) : c;
                    o = v >>> 9;
                    if (o > 2047) o = 2047;
                    dec++;
                    if (dec > 3) expq.push_back(int'(o));
                end
            end else begin
                en_c = 1'b0;
            end
            @(negedge clk);
            if (vld_c === 1'b1) begin
                pulses++;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_unexpected_valid cycle %0d: got %0d", n, out_c);
                end else begin
                    e = 12'(expq.pop_front());
                    if (out_c !== e) begin
                        failures++;
                        $display("FAIL wrap_model cycle %0d: got %0d, want %0d", n, out_c, e);
                    end
                end
                checks++;
                if (out_c !== 12'd1024) begin
                    failures++;
                    $display("FAIL wrap_const cycle %0d: got %0d, want 1024", n, out_c);
                end
            end
        end
        // 625 decimation points, first 3 suppressed
        checks++;
        if (pulses != 622) begin
            failures++;
            $display("FAIL wrap_pulse_count: got %0d, want 622", pulses);
        end
    endtask

    initial begin
        rst_a = 1'b0; clr_a = 1'b0; en_a = 1'b0; in_a = 2'b00;
        rst_b = 1'b0; clr_b = 1'b0; en_b = 1'b0; in_b = 1'b0;
        rst_c = 1'b0; clr_c = 1'b0; en_c = 1'b0; in_c = 1'b0;
        test_reset();
        test_full_scale();
        test_gapped();
        test_clear();
        test_async_reset();
        test_patterns();
        test_long_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
